// File: rtl/usb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_buffer_pkg
// Description : Shared types and defaults for the endpoint data buffer
//               controller: FSM state and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_buffer_pkg;

  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_RX_STORE  = 2'd0,
    REQ_TX_GET    = 2'd1,
    REQ_AHB_STORE = 2'd2,
    REQ_AHB_GET   = 2'd3
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/data_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_buffer_mem
// Description : DEPTH x 8 register file, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_buffer_mem
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [7:0]                 rdata
);

  logic [7:0] r_mem [DEPTH];

  // Byte write at the end of the cycle when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_buffer_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_buffer_controller
// Description : Schedules single-port byte accesses to the endpoint buffer
//               from USB RX/TX and AHB requesters. Owns pointers, occupancy,
//               round-robin and starvation state, and flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module data_buffer_controller
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     rx_store_req,
  input  logic [7:0]               rx_wdata,
  input  logic                     tx_get_req,
  input  logic                     ahb_store_req,
  input  logic [7:0]               ahb_wdata,
  input  logic                     ahb_get_req,
  output logic                     rx_store_gnt,
  output logic                     tx_get_gnt,
  output logic                     ahb_store_gnt,
  output logic                     ahb_get_gnt,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   buffer_occupancy,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] c_full   = OCC_W'(DEPTH);
  localparam logic [2:0]       c_starve = 3'(STARVE_LIMIT);

  localparam logic [1:0] c_idle  = IDLE;
  localparam logic [1:0] c_write = WRITE;
  localparam logic [1:0] c_read  = READ;

  logic [1:0]       r_state;
  req_id_e          r_sel;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [2:0]       r_wait;
  logic             r_last_ahb_get;
  logic             r_ovf;
  logic             r_udf;

  logic       w_arb;
  logic       w_store_ok;
  logic       w_get_ok;
  logic       w_rx_el;
  logic       w_tx_el;
  logic       w_as_el;
  logic       w_ag_el;
  logic       w_ahb_el;
  logic       w_ahb_pend;
  logic       w_promote;
  logic       w_win_valid;
  logic       w_win_ahb;
  logic       w_win_store;
  req_id_e    w_ahb_pick;
  req_id_e    w_win;
  logic       w_mem_we;
  logic [7:0] w_mem_wdata;
  logic [7:0] w_mem_rdata;

  // Arbitration only happens in an IDLE cycle that is not being flushed
  assign w_arb      = (r_state == c_idle) && !flush;
  assign w_store_ok = (r_occ < c_full);
  assign w_get_ok   = (r_occ != '0);
  assign w_rx_el    = rx_store_req  && w_store_ok;
  assign w_tx_el    = tx_get_req    && w_get_ok;
  assign w_as_el    = ahb_store_req && w_store_ok;
  assign w_ag_el    = ahb_get_req   && w_get_ok;
  assign w_ahb_el   = w_as_el || w_ag_el;
  assign w_ahb_pend = ahb_store_req || ahb_get_req;
  assign w_promote  = (r_wait >= c_starve) && w_ahb_el;

  // Pick the AHB candidate: on a tie the one not granted last time wins
  always_comb begin
    w_ahb_pick = REQ_AHB_STORE;
    if (w_as_el && w_ag_el) begin
      w_ahb_pick = r_last_ahb_get ? REQ_AHB_STORE : REQ_AHB_GET;
    end else if (w_ag_el) begin
      w_ahb_pick = REQ_AHB_GET;
    end
  end

  // Fixed priority rx > tx > AHB, unless a starved AHB pair is promoted
  always_comb begin
    w_win_valid = 1'b1;
    w_win       = REQ_RX_STORE;
    if (w_promote) begin
      w_win = w_ahb_pick;
    end else if (w_rx_el) begin
      w_win = REQ_RX_STORE;
    end else if (w_tx_el) begin
      w_win = REQ_TX_GET;
    end else if (w_ahb_el) begin
      w_win = w_ahb_pick;
    end else begin
      w_win_valid = 1'b0;
    end
  end

  assign w_win_ahb   = w_win_valid && ((w_win == REQ_AHB_STORE) || (w_win == REQ_AHB_GET));
  assign w_win_store = (w_win == REQ_RX_STORE) || (w_win == REQ_AHB_STORE);

  // Access FSM: IDLE -> WRITE/READ for one cycle -> IDLE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_idle;
      r_sel   <= REQ_RX_STORE;
    end else if (flush) begin
      r_state <= c_idle;
    end else if (r_state == c_idle) begin
      if (w_arb && w_win_valid) begin
        r_state <= w_win_store ? c_write : c_read;
        r_sel   <= w_win;
      end
    end else begin
      r_state <= c_idle;
    end
  end

  // Pointers and occupancy; a flush discards any access in flight
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (r_state == c_write) begin
      r_wptr <= r_wptr + 1'b1;
      r_occ  <= r_occ + 1'b1;
    end else if (r_state == c_read) begin
      r_rptr <= r_rptr + 1'b1;
      r_occ  <= r_occ - 1'b1;
    end
  end

  // Starvation counter and AHB round-robin memory
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wait         <= '0;
      r_last_ahb_get <= 1'b1;
    end else if (flush || !w_ahb_pend) begin
      r_wait <= '0;
    end else if (w_arb && w_win_valid) begin
      if (w_win_ahb) begin
        r_wait         <= '0;
        r_last_ahb_get <= (w_win == REQ_AHB_GET);
      end else if (w_ahb_el && (r_wait < c_starve)) begin
        r_wait <= r_wait + 3'd1;
      end
    end
  end

  // Error flags reflect requests blocked in the previous IDLE cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_arb && !w_store_ok && (rx_store_req || ahb_store_req);
      r_udf <= w_arb && !w_get_ok   && (tx_get_req   || ahb_get_req);
    end
  end

  // A write aborted by flush leaves memory untouched
  assign w_mem_we    = (r_state == c_write) && !flush;
  assign w_mem_wdata = (r_sel == REQ_RX_STORE) ? rx_wdata : ahb_wdata;

  data_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_wptr),
    .wdata (w_mem_wdata),
    .raddr (r_rptr),
    .rdata (w_mem_rdata)
  );

  assign rx_store_gnt     = (r_state == c_write) && (r_sel == REQ_RX_STORE);
  assign ahb_store_gnt    = (r_state == c_write) && (r_sel == REQ_AHB_STORE);
  assign tx_get_gnt       = (r_state == c_read)  && (r_sel == REQ_TX_GET);
  assign ahb_get_gnt      = (r_state == c_read)  && (r_sel == REQ_AHB_GET);
  assign rdata            = (r_state == c_read) ? w_mem_rdata : 8'h00;
  assign buffer_occupancy = r_occ;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_udf;

endmodule
`default_nettype wire
